// File: rtl/buster_mem_tester.sv
// Buster-bus memory tester: fills 0..last_addr, reads back, checks.
// Define MEM_TESTER_LFSR_EN to build the LFSR pattern selected by mode=1.
module buster_mem_tester #(
  parameter int          ADDR_WIDTH  = 24,
  parameter int          DATA_WIDTH  = 128,
  parameter logic [127:0] BASE       =
    128'hdeadbeefabad1deaba53b411fadebabe,
  parameter int          CYCLE_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   last_addr,
  input  logic                    mode,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [31:0]             error_count,
  output logic [ADDR_WIDTH-1:0]   first_error_addr,
  output logic [CYCLE_WIDTH-1:0]  write_cycles,
  output logic [CYCLE_WIDTH-1:0]  read_cycles,
  output logic                    bus_enable,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic                    bus_write,
  output logic [DATA_WIDTH-1:0]   bus_write_data,
  output logic [DATA_WIDTH/8-1:0] bus_write_byte_enable,
  input  logic                    bus_ready,
  input  logic [DATA_WIDTH-1:0]   bus_read_data,
  input  logic                    bus_read_data_valid
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int NW = DATA_WIDTH / 32;
  localparam logic [DATA_WIDTH-1:0] PBASE =
    BASE[DATA_WIDTH-1:0];

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_RWAIT, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]  chk_q, chk_d;
  logic [ADDR_WIDTH-1:0]  last_q, last_d;
  logic [ADDR_WIDTH-1:0]  first_q, first_d;
  logic [31:0]            err_q, err_d;
  logic [CYCLE_WIDTH-1:0] wcyc_q, wcyc_d;
  logic [CYCLE_WIDTH-1:0] rcyc_q, rcyc_d;
  logic [DATA_WIDTH-1:0]  wdata, exp_data;
  logic in_w, in_r, rd_hit, mismatch;

`ifdef MEM_TESTER_LFSR_EN
  localparam logic [31:0] TAPS = 32'h80200003;
  localparam logic [31:0] SEED = BASE[31:0] | 32'd1;
  logic        mode_q, mode_d;
  logic [31:0] lfw_q, lfw_d, lfc_q, lfc_d;

  function automatic logic [31:0] step(
    input logic [31:0] s
  );
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  assign in_w     = state_q == S_WRITE;
  assign in_r     = (state_q == S_READ) |
                    (state_q == S_RWAIT);
  assign rd_hit   = in_r & bus_read_data_valid;
  assign mismatch = bus_read_data != exp_data;

  // Pattern for the current write address and the next checked word
  always_comb begin
    wdata    = PBASE + DATA_WIDTH'(addr_q);
    exp_data = PBASE + DATA_WIDTH'(chk_q);
`ifdef MEM_TESTER_LFSR_EN
    if (mode_q) begin
      wdata    = {NW{lfw_q}} ^ PBASE;
      exp_data = {NW{lfc_q}} ^ PBASE;
    end
`endif
  end

  // Sequencer, request generation and response checking
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    chk_d   = chk_q;
    last_d  = last_q;
    first_d = first_q;
    err_d   = err_q;
    wcyc_d  = wcyc_q;
    rcyc_d  = rcyc_q;
`ifdef MEM_TESTER_LFSR_EN
    mode_d  = mode_q;
    lfw_d   = lfw_q;
    lfc_d   = lfc_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WRITE;
          addr_d  = '0;
          chk_d   = '0;
          last_d  = last_addr;
          first_d = '0;
          err_d   = '0;
          wcyc_d  = '0;
          rcyc_d  = '0;
`ifdef MEM_TESTER_LFSR_EN
          mode_d  = mode;
          lfw_d   = SEED;
          lfc_d   = SEED;
`endif
        end
      end
      S_WRITE: begin
        wcyc_d = wcyc_q + 1'b1;
        if (bus_ready) begin
          addr_d = addr_q + 1'b1;
`ifdef MEM_TESTER_LFSR_EN
          lfw_d  = step(lfw_q);
`endif
          if (addr_q == last_q) begin
            addr_d  = '0;
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        rcyc_d = rcyc_q + 1'b1;
        if (bus_ready) begin
          addr_d = addr_q + 1'b1;
          if (addr_q == last_q) state_d = S_RWAIT;
        end
      end
      S_RWAIT: rcyc_d = rcyc_q + 1'b1;
      default: state_d = S_IDLE;
    endcase
    if (rd_hit) begin
      chk_d = chk_q + 1'b1;
`ifdef MEM_TESTER_LFSR_EN
      lfc_d = step(lfc_q);
`endif
      if (mismatch) begin
        if (err_q != '1) err_d = err_q + 1'b1;
        if (err_q == '0) first_d = chk_q;
      end
      if (chk_q == last_q) state_d = S_DONE;
    end
  end

  // State registers; reset abandons any test in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      chk_q   <= '0;
      last_q  <= '0;
      first_q <= '0;
      err_q   <= '0;
      wcyc_q  <= '0;
      rcyc_q  <= '0;
`ifdef MEM_TESTER_LFSR_EN
      mode_q  <= 1'b0;
      lfw_q   <= '0;
      lfc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      chk_q   <= chk_d;
      last_q  <= last_d;
      first_q <= first_d;
      err_q   <= err_d;
      wcyc_q  <= wcyc_d;
      rcyc_q  <= rcyc_d;
`ifdef MEM_TESTER_LFSR_EN
      mode_q  <= mode_d;
      lfw_q   <= lfw_d;
      lfc_q   <= lfc_d;
`endif
    end
  end

  assign busy             = in_w | in_r;
  assign done             = state_q == S_DONE;
  assign pass             = done & (err_q == '0);
  assign error_count      = err_q;
  assign first_error_addr = first_q;
  assign write_cycles     = wcyc_q;
  assign read_cycles      = rcyc_q;
  assign bus_enable       = in_w | (state_q == S_READ);
  assign bus_addr         = addr_q;
  assign bus_write        = in_w;
  assign bus_write_data   = in_w ? wdata : '0;
  assign bus_write_byte_enable = {NB{in_w}};

endmodule
